io_bridge: RTL and testbench

- Buffers the stack processor's memory-mapped I/O between the datapath's input_IO/output_IO pins and an external valid/ready peripheral.
- Sits directly downstream of output_IO and upstream of input_IO.
- Holds a TX FIFO for processor writes and an RX FIFO for peripheral data, so I/O instructions never wait on the peripheral.
- Write and read strobes come from the control unit.

---
 rtl/io_bridge.sv | 113 +++++++++++
 tb/tb_io_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: TX and RX first-word-fall-through FIFOs between the
// stack processor's I/O pins and a valid/ready peripheral.
module io_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] output_IO,
    input  logic             out_wr,
    output logic [WIDTH-1:0] input_IO,
    input  logic             in_rd,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             tx_full,
    output logic             rx_empty,
    output logic [7:0]       tx_drop_cnt,
    output logic             rx_underrun
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] tx_mem_q [DEPTH];
    logic [WIDTH-1:0] rx_mem_q [DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
    logic [PTR_W:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]       tx_drop_cnt_q, tx_drop_cnt_d;
    logic             rx_underrun_q;

    logic tx_empty, rx_full;
    logic tx_push, tx_pop, tx_drop, rx_push, rx_pop;

    // Handshake: a word moves across a valid/ready pair at a rising edge where
    // both are high; ready never depends on valid, and valid, once high, only
    // drops after the transfer, so the two sides never form a combinational loop.
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    assign tx_pop  = tx_valid && tx_ready;
    assign tx_push = out_wr && (!tx_full || tx_pop);
    assign tx_drop = out_wr && tx_full && !tx_pop;
    assign rx_push = rx_valid && rx_ready;
    assign rx_pop  = in_rd && !rx_empty;

    assign tx_data     = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
    assign input_IO    = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
    assign tx_drop_cnt = tx_drop_cnt_q;
    assign rx_underrun = rx_underrun_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        tx_drop_cnt_d = tx_drop_cnt_q;
        if (tx_drop && (tx_drop_cnt_q != 8'hFF)) begin
            tx_drop_cnt_d = tx_drop_cnt_q + 8'd1;
        end
    end

    // Storage needs no reset: reads are masked by the counts whenever empty.
    always_ff @(posedge clk) begin
        if (!reset && tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= output_IO;
        end
        if (!reset && rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_cnt_q      <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_cnt_q      <= '0;
            tx_drop_cnt_q <= '0;
            rx_underrun_q <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
            tx_cnt_q      <= tx_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            tx_drop_cnt_q <= tx_drop_cnt_d;
            if (in_rd && rx_empty) rx_underrun_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed self-checking bench for io_bridge: TX/RX FIFO flow, full/empty
// boundaries, drop counter, underrun flag and mid-transfer reset.
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] output_IO, input_IO, tx_data, rx_data;
    logic        out_wr, in_rd, tx_valid, tx_ready, rx_valid, rx_ready;
    logic        tx_full, rx_empty, rx_underrun;
    logic [7:0]  tx_drop_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    io_bridge #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .output_IO(output_IO), .out_wr(out_wr),
        .input_IO(input_IO), .in_rd(in_rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_full(tx_full), .rx_empty(rx_empty),
        .tx_drop_cnt(tx_drop_cnt), .rx_underrun(rx_underrun)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx_valid"}, {15'd0, tx_valid}, 16'd0);
        check({tag, "_tx_full"}, {15'd0, tx_full}, 16'd0);
        check({tag, "_rx_empty"}, {15'd0, rx_empty}, 16'd1);
        check({tag, "_rx_ready"}, {15'd0, rx_ready}, 16'd1);
        check({tag, "_input_IO"}, input_IO, 16'h0000);
        check({tag, "_tx_data"}, tx_data, 16'h0000);
        check({tag, "_drop_cnt"}, {8'd0, tx_drop_cnt}, 16'd0);
        check({tag, "_underrun"}, {15'd0, rx_underrun}, 16'd0);
    endtask

    initial begin
        reset = 1'b1; out_wr = 1'b0; in_rd = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; output_IO = '0; rx_data = '0;
        tick(); tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Single TX word, then peripheral accepts it.
        output_IO = 16'hA5A5; out_wr = 1'b1;
        tick();
        out_wr = 1'b0;
        check("tx1_valid", {15'd0, tx_valid}, 16'd1);
        check("tx1_data", tx_data, 16'hA5A5);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx1_drained", {15'd0, tx_valid}, 16'd0);
        check("tx1_data0", tx_data, 16'h0000);

        // Five writes into a four-deep TX: fifth is dropped.
        for (int i = 1; i <= 5; i++) begin
            output_IO = 16'(i); out_wr = 1'b1;
            if (i <= 4) exp_q.push_back(16'(i));
            tick();
            if (i == 3) check("tx_not_full3", {15'd0, tx_full}, 16'd0);
            if (i == 4) check("tx_full4", {15'd0, tx_full}, 16'd1);
        end
        out_wr = 1'b0;
        check("tx_drop1", {8'd0, tx_drop_cnt}, 16'd1);
        check("tx_full5", {15'd0, tx_full}, 16'd1);

        // Full with simultaneous write and pop: write accepted, no drop.
        exp_w = exp_q.pop_front();
        check("tx_head_before_pp", tx_data, exp_w);
        output_IO = 16'd9; out_wr = 1'b1; tx_ready = 1'b1;
        exp_q.push_back(16'd9);
        tick();
        out_wr = 1'b0; tx_ready = 1'b0;
        check("tx_pp_full", {15'd0, tx_full}, 16'd1);
        check("tx_pp_drop", {8'd0, tx_drop_cnt}, 16'd1);

        // Drain against the expected queue: 2,3,4,9.
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check("tx_drain", tx_data, exp_w);
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        check("tx_drained_valid", {15'd0, tx_valid}, 16'd0);

        // RX: two words, read them, then underrun.
        rx_valid = 1'b1; rx_data = 16'h0011;
        tick();
        rx_data = 16'h0022;
        tick();
        rx_valid = 1'b0;
        check("rx_head1", input_IO, 16'h0011);
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
        check("rx_head2", input_IO, 16'h0022);
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
        check("rx_empty_data", input_IO, 16'h0000);
        check("rx_empty_flag", {15'd0, rx_empty}, 16'd1);
        check("rx_no_underrun", {15'd0, rx_underrun}, 16'd0);
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
        check("rx_underrun", {15'd0, rx_underrun}, 16'd1);
        tick();
        check("rx_underrun_sticky", {15'd0, rx_underrun}, 16'd1);
        check("rx_empty_after_ur", {15'd0, rx_empty}, 16'd1);

        // RX full: fifth word held until a slot frees.
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 16'h0100 + 16'(i);
            tick();
        end
        check("rx_full_ready", {15'd0, rx_ready}, 16'd0);
        rx_data = 16'h0104;
        tick();
        check("rx_held_ready", {15'd0, rx_ready}, 16'd0);
        check("rx_held_head", input_IO, 16'h0100);
        in_rd = 1'b1;
        tick();
        in_rd = 1'b0;
        check("rx_freed_ready", {15'd0, rx_ready}, 16'd1);
        check("rx_after_pop", input_IO, 16'h0101);
        tick();
        rx_valid = 1'b0;
        check("rx_refull_ready", {15'd0, rx_ready}, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            check("rx_drain", input_IO, 16'h0100 + 16'(i));
            in_rd = 1'b1;
            tick();
            in_rd = 1'b0;
        end
        check("rx_drain_empty", {15'd0, rx_empty}, 16'd1);

        // Same-cycle TX write and RX read with independent effects.
        rx_valid = 1'b1; rx_data = 16'hBEEF;
        tick();
        rx_valid = 1'b0;
        out_wr = 1'b1; output_IO = 16'h1234; in_rd = 1'b1;
        tick();
        out_wr = 1'b0; in_rd = 1'b0;
        check("indep_tx", tx_data, 16'h1234);
        check("indep_rx_empty", {15'd0, rx_empty}, 16'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Drop counter saturates at 255.
        for (int i = 0; i < 264; i++) begin
            out_wr = 1'b1; output_IO = 16'(i);
            tick();
        end
        out_wr = 1'b0;
        check("drop_saturate", {8'd0, tx_drop_cnt}, 16'd255);

        // Reset in the middle of active handshakes.
        tx_ready = 1'b1;
        tick();
        tick(); tick(); tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out_wr = 1'b1; output_IO = 16'h0A00 + 16'(i);
            if (i < 2) begin
                rx_valid = 1'b1; rx_data = 16'h0B00 + 16'(i);
            end else begin
                rx_valid = 1'b0;
            end
            tick();
        end
        out_wr = 1'b0;
        check("pre_rst_tx", tx_data, 16'h0A00);
        check("pre_rst_rx", input_IO, 16'h0B00);
        tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 16'h0BFF;
        out_wr = 1'b1; output_IO = 16'h0AFF; in_rd = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; out_wr = 1'b0; in_rd = 1'b0;
        check_reset_state("mid_rst");
        tick();
        check_reset_state("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
